divider_iterative: RTL and testbench
====================================

Name: divider_iterative

Overview:
- Sequential RV32M divide unit: DIV, DIVU, REM, REMU. Inverse operation to the combinational MUL/MULH/MULHSU/MULHU multiplier.
- Sits in the EX stage beside the multiplier. The pipeline controller stalls on busy and captures div_out when out_valid pulses.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Divide-by-zero and signed overflow complete on a one-cycle fast path.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- op1  input  DATA_WIDTH  dividend (rs1).
- op2  input  DATA_WIDTH  divisor (rs2).
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  one-cycle completion pulse.
- div_out  output  DATA_WIDTH  result; holds its value until the next completion or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, out_valid=0, div_out=0, counter=0. All internal registers cleared. A reset during CALC/FIX aborts the operation; no out_valid is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge k:
  - Latch funct3, the operand signs, |op1| and |op2|. Absolute values are taken only for DIV/REM; DIVU/REMU use the raw operands.
  - Clear remainder, counter=0.
  - If op2==0 or (signed op and op1==0x80000000 and op2==0xFFFFFFFF): write the fast-path result into div_out and go to DONE. out_valid is then high in the cycle after edge k (latency 1).
  - Otherwise go to CALC.
- CALC, one iteration per edge:
  - rem_shift = {rem[30:0], dvd[31]}; shift dvd left.
  - If rem_shift >= divisor: rem = rem_shift - divisor, quotient bit = 1. Else rem = rem_shift, quotient bit = 0.
  - Use a 33-bit subtract and check its borrow.
  - counter increments; after the iteration with counter==31, go to FIX (32 CALC edges, k+1..k+32).
- FIX (edge k+33):
  - Signed quotient is negated if sign(op1) XOR sign(op2).
  - Signed remainder is negated if sign(op1); the remainder takes the dividend's sign.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into div_out; go to DONE.
  - Normal-path latency: out_valid is high in the cycle after edge k+33, i.e. 34 cycles after start is sampled.
- DONE: out_valid=1 for exactly this cycle; go to IDLE on the next edge.
- Fast-path results:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op1.
  - Overflow: DIV returns 0x80000000; REM returns 0.
- funct3[2]==0 on start: accepted; div_out=0 via the fast path (latency 1).
- start while busy (CALC/FIX/DONE): ignored, with no effect on the operation in flight.
- op1/op2/funct3 changes after the accept edge: no effect (operands are latched).
- start asserted in the same cycle as the IDLE re-entry edge: accepted only once state==IDLE is sampled; back-to-back operations therefore have at least one IDLE cycle between them.
- Edge cases the normal path must get right:
  - op1 == 0: result 0, normal-path latency.
  - |op1| < |op2|: quotient 0, remainder = op1 including its sign.

Test Plan:
- DIV 7/-2 (0x00000007, 0xFFFFFFFE) -> div_out=0xFFFFFFFD, out_valid 34 cycles after start. REM on the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/3 -> 0x55555555; REMU 100/7 -> 0x00000002.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, each with out_valid one cycle after start and busy high for exactly 1 cycle.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0x00000000; latency 1.
- Start DIVU 100/7; change op1/op2 and pulse start again at cycle 5 -> second start ignored, result still 14 (0x0000000E), single out_valid pulse; div_out holds 14 until the next completion.
- Start DIV 1000/3; assert rst asynchronously mid-cycle at cycle 10 -> busy, out_valid and div_out go to 0 immediately, no out_valid pulse follows. After rst drops, DIV 1000/3 -> 0x0000014D at the normal 34-cycle latency.

Source files
------------

// File: rtl/divider_iterative_if.sv
// Request/result bundle between the EX-stage controller and the iterative divider.
// Handshake: a request is taken on the rising edge where start=1 and busy=0 (the
// unit is idle). busy stays high from the next cycle until the unit is idle again.
// out_valid pulses for exactly one cycle with the result on div_out. div_out then
// holds until the next completion.
interface divider_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [2:0]            funct3;
  logic                  busy;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] div_out;

  modport master (
    output start, op1, op2, funct3,
    input  busy, out_valid, div_out
  );

  modport slave (
    input  start, op1, op2, funct3,
    output busy, out_valid, div_out
  );
endinterface

// File: rtl/divider_iterative.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divide, one quotient bit per
// cycle, with a one-cycle fast path for divide-by-zero, signed overflow and non-divide funct3.
module divider_iterative #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  divider_iterative_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ALL_ONE = {W{1'b1}};
  localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic          is_rem;
  logic          is_sgn;
  logic          neg1;
  logic          neg2;
  logic [W-1:0]  dvd;      // dividend in, quotient bits shift in from the bottom
  logic [W-1:0]  dvs;
  logic [W-1:0]  rem;
  logic [CW-1:0] counter;

  logic          req_sgn;
  logic          fast;
  logic [W-1:0]  fast_res;
  logic [W-1:0]  rem_shift;
  logic [W:0]    sub;
  logic          borrow;
  logic [W-1:0]  fix_res;

  assign dbg_state = state;

  always_comb begin
    req_sgn  = bus.funct3[2] & ~bus.funct3[0];
    fast     = 1'b0;
    fast_res = '0;
    if (!bus.funct3[2]) begin
      fast = 1'b1;
    end else if (bus.op2 == '0) begin
      fast     = 1'b1;
      fast_res = bus.funct3[1] ? bus.op1 : ALL_ONE;
    end else if (req_sgn && bus.op1 == MIN_NEG && bus.op2 == ALL_ONE) begin
      fast     = 1'b1;
      fast_res = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  // rem[W-1] acts as the 33rd bit of the shifted remainder: when it is set the
  // partial remainder already exceeds any divisor, so there can be no borrow.
  always_comb begin
    rem_shift = {rem[W-2:0], dvd[W-1]};
    sub       = {1'b0, rem_shift} - {1'b0, dvs};
    borrow    = sub[W] & ~rem[W-1];
  end

  always_comb begin
    fix_res = '0;
    if (is_rem) fix_res = (is_sgn && neg1) ? -rem : rem;
    else        fix_res = (is_sgn && (neg1 ^ neg2)) ? -dvd : dvd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      is_rem        <= 1'b0;
      is_sgn        <= 1'b0;
      neg1          <= 1'b0;
      neg2          <= 1'b0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      counter       <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.div_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          if (bus.start) begin
            is_rem   <= bus.funct3[1];
            is_sgn   <= req_sgn;
            neg1     <= req_sgn & bus.op1[W-1];
            neg2     <= req_sgn & bus.op2[W-1];
            dvd      <= (req_sgn && bus.op1[W-1]) ? -bus.op1 : bus.op1;
            dvs      <= (req_sgn && bus.op2[W-1]) ? -bus.op2 : bus.op2;
            rem      <= '0;
            counter  <= '0;
            bus.busy <= 1'b1;
            if (fast) begin
              bus.div_out   <= fast_res;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd     <= {dvd[W-2:0], ~borrow};
          rem     <= borrow ? rem_shift : sub[W-1:0];
          counter <= counter + 1'b1;
          if (counter == LAST) state <= FIX;
        end
        FIX: begin
          bus.div_out   <= fix_res;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_iterative.sv
// Bench for divider_iterative: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for busy-start and async reset.
module tb_divider_iterative;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  divider_iterative_if #(.DATA_WIDTH(32)) dif ();

  divider_iterative #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (!f[2]) return 32'h0;
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'h0 : 32'h8000_0000;
    if (f[0]) return f[1] ? (a % b) : (a / b);
    return f[1] ? (sa % sb) : (sa / sb);
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f);
    if (!f[2] || b == 32'h0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drives one request from a negedge; lat counts cycles from the accept edge
  // until out_valid is seen. poke>0 re-pulses start with new operands that cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input int poke, output logic [31:0] res, output int lat,
                       output int busy_n);
    bit seen;
    @(negedge clk);
    check("idle_busy", {31'b0, dif.busy}, 32'h0);
    check("idle_valid", {31'b0, dif.out_valid}, 32'h0);
    dif.op1 = a;
    dif.op2 = b;
    dif.funct3 = f;
    dif.start = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_n = 0;
    seen = 1'b0;
    res = '0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      dif.op1 = $urandom;
      dif.op2 = $urandom;
      dif.funct3 = 3'($urandom_range(0, 7));
      dif.start = (poke != 0 && lat == poke);
      if (dif.busy) busy_n++;
      if (dif.out_valid) begin
        seen = 1'b1;
        res = dif.div_out;
      end
    end
    dif.start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no out_valid within %0d cycles expected 1 pulse", lat);
    end
  endtask

  logic [31:0] res;
  int          lat;
  int          busy_n;
  int          pulses;

  initial begin
    dif.start = 1'b0;
    dif.op1 = '0;
    dif.op2 = '0;
    dif.funct3 = 3'b100;

    vecs[0]  = '{32'h0000_0007, 32'hFFFF_FFFE, 3'b100, 32'hFFFF_FFFD, 34};
    vecs[1]  = '{32'h0000_0007, 32'hFFFF_FFFE, 3'b110, 32'h0000_0001, 34};
    vecs[2]  = '{32'hFFFF_FFF9, 32'h0000_0002, 3'b100, 32'hFFFF_FFFD, 34};
    vecs[3]  = '{32'hFFFF_FFF9, 32'h0000_0002, 3'b110, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0003, 3'b101, 32'h5555_5555, 34};
    vecs[5]  = '{32'd100,       32'd7,         3'b111, 32'h0000_0002, 34};
    vecs[6]  = '{32'd5,         32'd0,         3'b100, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{32'd5,         32'd0,         3'b111, 32'h0000_0005, 1};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'h8000_0000, 1};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h0000_0000, 1};
    vecs[10] = '{32'd1234,      32'd5,         3'b000, 32'h0000_0000, 1};
    vecs[11] = '{32'd0,         32'd5,         3'b100, 32'h0000_0000, 34};
    vecs[12] = '{32'hFFFF_FFFD, 32'd7,         3'b110, 32'hFFFF_FFFD, 34};
    vecs[13] = '{32'hFFFF_FFFD, 32'd7,         3'b100, 32'h0000_0000, 34};
    vecs[14] = '{32'hFFFF_FFFF, 32'h8000_0001, 3'b101, 32'h0000_0001, 34};
    vecs[15] = '{32'hFFFF_FFFF, 32'h8000_0001, 3'b111, 32'h7FFF_FFFE, 34};
    vecs[16] = '{32'd1000,      32'd3,         3'b100, 32'h0000_014D, 34};
    vecs[17] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000, 34};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, dif.busy}, 32'h0);
    check("rst_valid", {31'b0, dif.out_valid}, 32'h0);
    check("rst_out", dif.div_out, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, 0, res, lat, busy_n);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), busy_n, vecs[i].lat);
    end

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      exp_q.push_back(model(a, b, f));
      do_op(a, b, f, 0, res, lat, busy_n);
      check("rand_res", res, exp_q.pop_front());
      check("rand_lat", lat, model_lat(a, b, f));
    end

    // Second start while busy must be ignored; div_out then holds.
    do_op(32'd100, 32'd7, 3'b101, 5, res, lat, busy_n);
    check("poke_res", res, 32'h0000_000E);
    check("poke_lat", lat, 34);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.out_valid) pulses++;
    end
    check("poke_pulses", pulses, 0);
    check("poke_hold", dif.div_out, 32'h0000_000E);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    dif.op1 = 32'd1000;
    dif.op2 = 32'd3;
    dif.funct3 = 3'b100;
    dif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, dif.busy}, 32'h0);
    check("arst_valid", {31'b0, dif.out_valid}, 32'h0);
    check("arst_out", dif.div_out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.out_valid) pulses++;
    end
    check("arst_no_pulse", pulses, 0);
    do_op(32'd1000, 32'd3, 3'b100, 0, res, lat, busy_n);
    check("arst_after_res", res, 32'h0000_014D);
    check("arst_after_lat", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
